// File: rtl/uart_rx_os16.sv
// 8N1 UART receiver driven by a 16x oversampling enable, with 2-flop input
// synchronizer, 3-sample majority vote per bit and a single-entry holding register.
module uart_rx_os16 #(
   parameter int DATA_BITS = 8,
   parameter int OVS       = 16
) (
   input  logic       clk_50m,
   input  logic       rst_n,
   input  logic       rxclk_en,
   input  logic       rx,
   input  logic       rdy_clr,
   output logic [7:0] data,
   output logic       rdy,
   output logic       frame_err,
   output logic       overrun
);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   localparam logic [3:0] CNT_LAST = 4'(OVS - 1);
   localparam logic [3:0] CNT_MID  = 4'(OVS / 2);
   localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);

   state_t               state;
   logic                 rx_m, rx_s;
   logic [3:0]           cnt;
   logic [3:0]           cnt_nxt;
   logic [2:0]           bit_idx;
   logic [DATA_BITS-1:0] shreg;
   logic                 v_a, v_b, v_c;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   // cnt holds the count of the most recent tick; cnt_nxt is this tick's count
   assign cnt_nxt = cnt + 4'd1;

   always_ff @(posedge clk_50m) begin
      if (!rst_n) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
      end else begin
         rx_m <= rx;
         rx_s <= rx_m;
      end
   end

   always_ff @(posedge clk_50m) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         bit_idx   <= 3'd0;
         shreg     <= '0;
         v_a       <= 1'b1;
         v_b       <= 1'b1;
         v_c       <= 1'b1;
         data      <= 8'd0;
         rdy       <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (rdy_clr) begin
            rdy       <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
         end
         if (rxclk_en) begin
            if (state != IDLE) begin
               cnt <= cnt_nxt;
               if (cnt_nxt == CNT_MID - 4'd1) v_a <= rx_s;
               if (cnt_nxt == CNT_MID)        v_b <= rx_s;
               if (cnt_nxt == CNT_MID + 4'd1) v_c <= rx_s;
            end
            case (state)
               IDLE: begin
                  if (!rx_s) begin
                     state <= START;
                     cnt   <= 4'd0;
                  end
               end
               START: begin
                  if (cnt_nxt == CNT_MID + 4'd1 && maj3(v_a, v_b, rx_s)) begin
                     state <= IDLE;
                     cnt   <= 4'd0;
                  end else if (cnt_nxt == CNT_LAST) begin
                     state   <= DATA;
                     bit_idx <= 3'd0;
                  end
               end
               DATA: begin
                  if (cnt_nxt == CNT_LAST) begin
                     shreg   <= {maj3(v_a, v_b, v_c), shreg[DATA_BITS-1:1]};
                     bit_idx <= bit_idx + 3'd1;
                     if (bit_idx == BIT_LAST) state <= STOP;
                  end
               end
               STOP: begin
                  // Decide mid-stop-bit so a following start edge is not missed
                  if (cnt_nxt == CNT_MID + 4'd1) begin
                     state <= IDLE;
                     cnt   <= 4'd0;
                     if (maj3(v_a, v_b, rx_s)) begin
                        data      <= 8'(shreg);
                        rdy       <= 1'b1;
                        frame_err <= 1'b0;
                        if (rdy && !rdy_clr) overrun <= 1'b1;
                     end else begin
                        frame_err <= 1'b1;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_os16.sv
// Directed bench for uart_rx_os16: frames, glitch, noise, framing error,
// overrun, clear/complete coincidence and mid-frame reset.
module tb_uart_rx_os16;

   logic       clk_50m = 1'b0;
   logic       rst_n   = 1'b0;
   logic       rxclk_en = 1'b0;
   logic       rx      = 1'b1;
   logic       rdy_clr = 1'b0;
   logic [7:0] data;
   logic       rdy, frame_err, overrun;

   int nvec = 0;
   int nerr = 0;

   uart_rx_os16 dut (
      .clk_50m  (clk_50m),
      .rst_n    (rst_n),
      .rxclk_en (rxclk_en),
      .rx       (rx),
      .rdy_clr  (rdy_clr),
      .data     (data),
      .rdy      (rdy),
      .frame_err(frame_err),
      .overrun  (overrun)
   );

   always #10 clk_50m = ~clk_50m;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [7:0] d, input logic r,
                          input logic fe, input logic ov);
      chk({tag, ".data"}, data, d);
      chk({tag, ".rdy"}, {7'd0, rdy}, {7'd0, r});
      chk({tag, ".frame_err"}, {7'd0, frame_err}, {7'd0, fe});
      chk({tag, ".overrun"}, {7'd0, overrun}, {7'd0, ov});
   endtask

   // rx changes 3 clocks before the enable edge so the synchronizer has settled
   task automatic tick(input logic clr);
      repeat (3) @(negedge clk_50m);
      rxclk_en = 1'b1;
      rdy_clr  = clr;
      @(negedge clk_50m);
      rxclk_en = 1'b0;
      rdy_clr  = 1'b0;
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) tick(1'b0);
   endtask

   task automatic pulse_clr();
      @(negedge clk_50m);
      rdy_clr = 1'b1;
      @(negedge clk_50m);
      rdy_clr = 1'b0;
   endtask

   // Ends right after the stop-bit count-9 tick; gbit/gcnt invert one data tick
   task automatic send_frame(input logic [7:0] b, input logic stop_v, input int gbit,
                             input int gcnt, input logic clr_end);
      rx = 1'b0;
      repeat (16) tick(1'b0);
      for (int i = 0; i < 8; i++) begin
         for (int c = 0; c < 16; c++) begin
            rx = (i == gbit && c == gcnt) ? ~b[i] : b[i];
            tick(1'b0);
         end
      end
      rx = stop_v;
      for (int c = 0; c < 10; c++) tick((c == 9) ? clr_end : 1'b0);
      rx = 1'b1;
   endtask

   initial begin
      repeat (3) @(negedge clk_50m);
      rst_n = 1'b1;
      chk_all("reset", 8'h00, 1'b0, 1'b0, 1'b0);
      idle(4);

      send_frame(8'hA5, 1'b1, -1, 0, 1'b0);
      chk_all("frame_a5", 8'hA5, 1'b1, 1'b0, 1'b0);
      idle(6);
      pulse_clr();
      chk("a5_clr.rdy", {7'd0, rdy}, 8'h00);

      rx = 1'b0;
      repeat (4) tick(1'b0);
      rx = 1'b1;
      repeat (6) tick(1'b0);
      chk_all("glitch", 8'hA5, 1'b0, 1'b0, 1'b0);
      idle(4);
      send_frame(8'h3C, 1'b1, -1, 0, 1'b0);
      chk_all("after_glitch_3c", 8'h3C, 1'b1, 1'b0, 1'b0);
      idle(6);
      pulse_clr();

      send_frame(8'h00, 1'b1, 3, 8, 1'b0);
      chk_all("noise_00", 8'h00, 1'b1, 1'b0, 1'b0);
      idle(6);
      pulse_clr();

      send_frame(8'h3C, 1'b0, -1, 0, 1'b0);
      chk_all("frame_err_3c", 8'h00, 1'b0, 1'b1, 1'b0);
      idle(6);
      send_frame(8'h81, 1'b1, -1, 0, 1'b0);
      chk_all("good_81", 8'h81, 1'b1, 1'b0, 1'b0);
      idle(6);
      pulse_clr();

      send_frame(8'h11, 1'b1, -1, 0, 1'b0);
      chk_all("ovr_11", 8'h11, 1'b1, 1'b0, 1'b0);
      send_frame(8'h22, 1'b1, -1, 0, 1'b0);
      chk_all("ovr_22", 8'h22, 1'b1, 1'b0, 1'b1);
      idle(6);
      pulse_clr();
      chk_all("ovr_clr", 8'h22, 1'b0, 1'b0, 1'b0);

      send_frame(8'h11, 1'b1, -1, 0, 1'b0);
      chk_all("coin_11", 8'h11, 1'b1, 1'b0, 1'b0);
      send_frame(8'h22, 1'b1, -1, 0, 1'b1);
      chk_all("coin_22", 8'h22, 1'b1, 1'b0, 1'b0);
      idle(6);

      rx = 1'b0;
      repeat (16) tick(1'b0);
      rx = 1'b1;
      repeat (4 * 16 + 8) tick(1'b0);
      @(negedge clk_50m);
      rst_n = 1'b0;
      @(negedge clk_50m);
      rst_n = 1'b1;
      chk_all("mid_reset", 8'h00, 1'b0, 1'b0, 1'b0);
      idle(20);
      chk_all("post_reset_idle", 8'h00, 1'b0, 1'b0, 1'b0);
      send_frame(8'h5A, 1'b1, -1, 0, 1'b0);
      chk_all("frame_5a", 8'h5A, 1'b1, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/uart_rx_os16.md
Name: uart_rx_os16

Overview:
- UART receiver. Decodes an 8N1-style serial stream using the 16x oversampling enable from the baud-rate generator (rxclk_en).
- Sits between the pad-side rx line and the byte consumer.
- Provides a single-entry holding register with ready / clear handshake, plus framing-error and overrun flags.
- Receive-side counterpart to the transmit path driven by txclk_en.

Parameters:
- DATA_BITS, 8, data bits per frame; legal range 5..8, LSB first. Unused MSBs of data read as 0.
- OVS, 16, rxclk_en ticks per bit. Fixed at 16; sample points below assume it.

Ports:
- clk_50m  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- rxclk_en  in  1  one-cycle enable pulse at 16x baud; all state advance is gated by it.
- rx  in  1  asynchronous serial input; idle high.
- rdy_clr  in  1  consumer acknowledge; clears rdy and overrun.
- data  out  8  last received byte.
- rdy  out  1  a byte is held in data and has not been acknowledged.
- frame_err  out  1  last frame had a low stop bit.
- overrun  out  1  a byte completed while rdy was still 1.

Behaviour:
- Reset (rst_n=0 at a clk_50m edge), also applies mid-frame:
  - state=IDLE, sample counter=0, bit index=0, shift register=0.
  - data=0, rdy=0, frame_err=0, overrun=0.
  - Synchronizer flops preset to 1.
  - Any partial frame is discarded.
- Input synchronization:
  - rx passes through 2 flops to form rx_s; all decisions use rx_s.
  - Latency from rx to rx_s is 2 clk_50m cycles.
- Sample counter: 4 bits; increments on each rxclk_en while not IDLE; wraps 15->0 at each bit boundary.
- Majority vote: at counts 7, 8 and 9 of a bit, rx_s is captured; bit value = at least 2 of 3 captures high.
- States:
  - IDLE:
    - On an rxclk_en with rx_s=0: go to START, counter=0. That tick is sample 0 of the start bit.
  - START:
    - Vote taken at counts 7/8/9.
    - At count 9: vote=1 -> IDLE (glitch rejected, no flags change); vote=0 -> remain until count 15.
    - At count 15: go to DATA, bit index=0.
  - DATA:
    - At count 15: shift voted bit into the shift register (LSB first), bit index++.
    - After bit DATA_BITS-1: go to STOP.
  - STOP:
    - Vote taken at counts 7/8/9; decision at count 9, then IDLE. Early return lets a following start bit be detected within half a bit.
    - Stop vote=1: data <= shift register, rdy <= 1, frame_err <= 0. If rdy was already 1 and rdy_clr is not asserted this cycle, also overrun <= 1.
    - Stop vote=0: frame_err <= 1; data and rdy unchanged; byte discarded.
- Output timing: data, rdy and flags update on the clk_50m edge of the rxclk_en tick at stop-bit count 9 (registered, no extra cycle).
- rdy_clr handling:
  - rdy_clr=1: rdy <= 0, overrun <= 0, frame_err <= 0.
  - If rdy_clr coincides with a good stop decision, the set wins: rdy=1, data=new byte, overrun=0.
- rxclk_en=0: no state, counter or sampling change. rx_s still tracks rx.
- rdy_clr is level-sensitive; holding it high keeps rdy low only until the next completed byte, because the set wins.

Test Plan:
- Frame 0xA5: start bit, LSB first, stop=1, each bit 16 ticks -> at stop count 9: data=0xA5, rdy=1, frame_err=0, overrun=0. Then rdy_clr pulse -> rdy=0.
- Start glitch: rx low for 4 ticks then high -> state back to IDLE at count 9; rdy, data, flags unchanged. A following valid 0x3C is received correctly.
- Noise rejection: frame 0x00 with rx forced high only at count 8 of bit 3 -> vote 0; data=0x00, rdy=1.
- Framing error: frame 0x3C with stop bit 0 -> frame_err=1, rdy=0, data keeps previous value. A next good frame 0x81 -> frame_err=0, data=0x81.
- Overrun and coincidence:
  - 0x11 then 0x22 back-to-back without rdy_clr -> data=0x22, rdy=1, overrun=1.
  - Repeat with rdy_clr on the exact completion cycle of 0x22 -> rdy=1, overrun=0.
- Reset mid-frame: rst_n=0 for 1 cycle during data bit 4 -> all outputs 0, state IDLE. A next frame 0x5A gives data=0x5A, rdy=1.
